// File: rtl/ec_ctrl_pkg.sv
// Shared definitions for the EC stripe sequencer: default geometry, derived widths
// and the control FSM state encoding.
package ec_ctrl_pkg;

  localparam int K_MAX_DEF = 8;
  localparam int M_MAX_DEF = 4;
  localparam int W_DEF     = 8;

  localparam int K_W_DEF   = $clog2(K_MAX_DEF + 1);
  localparam int M_W_DEF   = $clog2(M_MAX_DEF + 1);
  localparam int P_W_DEF   = $clog2(M_MAX_DEF);
  localparam int CNT_W_DEF = $clog2(K_MAX_DEF * W_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    BM_LOAD,
    RUN,
    DRAIN,
    WRITE,
    NEXT,
    DONE
  } state_t;

  // Counter width able to hold k*w inclusive.
  function automatic int cnt_width(input int k_max, input int w);
    return $clog2(k_max * w + 1);
  endfunction

endpackage

// File: rtl/ec_bm_fetch.sv
// Bitmatrix slice fetch for one parity row: issues k*W in-order read requests and
// counts the returns; counters clear whenever the fetch is not active.
module ec_bm_fetch
  import ec_ctrl_pkg::*;
#(
  parameter int K_MAX         = K_MAX_DEF,
  parameter int M_MAX         = M_MAX_DEF,
  parameter int W             = W_DEF,
  parameter int BM_MEM_ADDR_W = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         active,
  input  logic                         abort,
  input  logic [$clog2(K_MAX+1)-1:0]   k,
  input  logic [$clog2(M_MAX)-1:0]     parity_idx,
  input  logic                         bm_rd_data_val,
  output logic                         bm_rd_req,
  output logic [BM_MEM_ADDR_W-1:0]     bm_rd_addr,
  output logic                         first,
  output logic                         load_done
);

  localparam int C_W = cnt_width(K_MAX, W);
  localparam logic [BM_MEM_ADDR_W-1:0] ROW_STRIDE = BM_MEM_ADDR_W'(K_MAX * W);

  logic [C_W-1:0] total;
  logic [C_W-1:0] req_cnt_q;
  logic [C_W-1:0] ret_cnt_q;

  assign total      = C_W'(k) * C_W'(W);
  assign bm_rd_req  = active && !abort && (req_cnt_q < total);
  assign bm_rd_addr = BM_MEM_ADDR_W'(parity_idx) * ROW_STRIDE + BM_MEM_ADDR_W'(req_cnt_q);
  assign first      = active && (req_cnt_q == '0);
  assign load_done  = active && (ret_cnt_q == total);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      if (bm_rd_req)
        req_cnt_q <= req_cnt_q + C_W'(1);
      // Returns arriving outside an active load are dropped by the clear above.
      if (bm_rd_data_val && ret_cnt_q != total)
        ret_cnt_q <= ret_cnt_q + C_W'(1);
    end
  end

endmodule

// File: rtl/ec_stripe_sequencer.sv
// Stripe sequencer: per stripe and parity row, loads the bitmatrix slice, streams K
// input words into the engine, drains its pipeline and writes one parity word.
module ec_stripe_sequencer
  import ec_ctrl_pkg::*;
#(
  parameter int K_MAX         = K_MAX_DEF,
  parameter int M_MAX         = M_MAX_DEF,
  parameter int W             = W_DEF,
  parameter int BM_MEM_ADDR_W = 10,
  parameter int STRIPE_W      = 16,
  parameter int ENG_LAT       = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_en,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
  input  logic [$clog2(M_MAX+1)-1:0]   cfg_m,
  input  logic [STRIPE_W-1:0]          cfg_num_stripes,
  output logic                         bm_rd_req,
  output logic [BM_MEM_ADDR_W-1:0]     bm_rd_addr,
  input  logic                         bm_rd_data_val,
  input  logic                         inbuf_empty,
  output logic                         inbuf_rd_en,
  output logic                         eng_clr,
  output logic                         eng_calc_en,
  input  logic                         eng_empty,
  input  logic                         outbuf_full,
  output logic                         outbuf_wr_en,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [STRIPE_W-1:0]          stripe_idx,
  output logic [$clog2(M_MAX)-1:0]     parity_idx
);

  localparam int K_W = $clog2(K_MAX + 1);
  localparam int M_W = $clog2(M_MAX + 1);
  localparam int L_W = $clog2(ENG_LAT + 1);
  localparam logic [K_W-1:0] K_MAX_V = K_W'(K_MAX);
  localparam logic [M_W-1:0] M_MAX_V = M_W'(M_MAX);
  localparam logic [L_W-1:0] LAT_END = L_W'(ENG_LAT - 1);

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q;
  logic [M_W-1:0]      m_q;
  logic [STRIPE_W-1:0] num_q;
  logic [K_W-1:0]      pop_cnt_q;
  logic [K_W-1:0]      calc_cnt_q;
  logic                calc_q;
  logic [L_W-1:0]      lat_q;
  logic                err_q;
  logic                abort_clr_q;

  logic cfg_ok, job_start, aborting, last_row, last_stripe;
  logic fetch_first, load_done;

  assign cfg_ok = (cfg_k != '0) && (cfg_k <= K_MAX_V) &&
                  (cfg_m != '0) && (cfg_m <= M_MAX_V) &&
                  (cfg_num_stripes != '0);
  assign job_start   = (state_q == IDLE) && start && cfg_en && cfg_ok;
  assign aborting    = abort && (state_q != IDLE);
  assign last_row    = (M_W'(parity_idx) == m_q - M_W'(1));
  assign last_stripe = (stripe_idx == num_q - STRIPE_W'(1));

  ec_bm_fetch #(
    .K_MAX         (K_MAX),
    .M_MAX         (M_MAX),
    .W             (W),
    .BM_MEM_ADDR_W (BM_MEM_ADDR_W)
  ) u_bm_fetch (
    .clk            (clk),
    .rst            (rst),
    .active         (state_q == BM_LOAD),
    .abort          (abort),
    .k              (k_q),
    .parity_idx     (parity_idx),
    .bm_rd_data_val (bm_rd_data_val),
    .bm_rd_req      (bm_rd_req),
    .bm_rd_addr     (bm_rd_addr),
    .first          (fetch_first),
    .load_done      (load_done)
  );

  assign inbuf_rd_en  = (state_q == RUN) && (pop_cnt_q < k_q) && !inbuf_empty && !abort;
  assign eng_calc_en  = calc_q;
  assign outbuf_wr_en = (state_q == WRITE) && !outbuf_full && !abort;
  assign eng_clr      = fetch_first || abort_clr_q;
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign err          = err_q;

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_start) state_d = BM_LOAD;
      BM_LOAD: if (load_done) state_d = RUN;
      RUN:     if (calc_q && calc_cnt_q == k_q - K_W'(1)) state_d = DRAIN;
      DRAIN:   if (lat_q >= LAT_END && eng_empty) state_d = WRITE;
      WRITE:   if (!outbuf_full) state_d = NEXT;
      NEXT:    state_d = (last_row && last_stripe) ? DONE : BM_LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (aborting)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      m_q         <= '0;
      num_q       <= '0;
      stripe_idx  <= '0;
      parity_idx  <= '0;
      pop_cnt_q   <= '0;
      calc_cnt_q  <= '0;
      calc_q      <= 1'b0;
      lat_q       <= '0;
      err_q       <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= (state_q == IDLE) && start && cfg_en && !cfg_ok;
      abort_clr_q <= aborting;
      calc_q      <= inbuf_rd_en;

      if (job_start) begin
        k_q        <= cfg_k;
        m_q        <= cfg_m;
        num_q      <= cfg_num_stripes;
        stripe_idx <= '0;
        parity_idx <= '0;
      end

      if (state_q != RUN) begin
        pop_cnt_q  <= '0;
        calc_cnt_q <= '0;
      end else begin
        if (inbuf_rd_en) pop_cnt_q  <= pop_cnt_q + K_W'(1);
        if (calc_q)      calc_cnt_q <= calc_cnt_q + K_W'(1);
      end

      // Cycles elapsed since the last calc_en, saturating once the latency is covered.
      if (state_q != DRAIN)
        lat_q <= '0;
      else if (lat_q < LAT_END)
        lat_q <= lat_q + L_W'(1);

      // On the final row of the final stripe the indices keep the last values processed.
      if (state_q == NEXT && !abort) begin
        if (!last_row) begin
          parity_idx <= parity_idx + 1'b1;
        end else if (!last_stripe) begin
          parity_idx <= '0;
          stripe_idx <= stripe_idx + STRIPE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ec_stripe_sequencer.sv
// Directed bench for ec_stripe_sequencer with a fixed-latency bitmatrix memory model,
// a simple engine-occupancy model and event counters checked against hand-computed totals.
module tb_ec_stripe_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cfg_k = '0;
  logic [2:0]  cfg_m = '0;
  logic [15:0] cfg_num_stripes = '0;
  logic        bm_rd_req;
  logic [9:0]  bm_rd_addr;
  logic        bm_rd_data_val;
  logic        inbuf_empty;
  logic        inbuf_rd_en;
  logic        eng_clr;
  logic        eng_calc_en;
  logic        eng_empty;
  logic        outbuf_full = 1'b0;
  logic        outbuf_wr_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] stripe_idx;
  logic [1:0]  parity_idx;

  logic empty_fixed = 1'b0;
  logic empty_toggle = 1'b0;
  logic empty_phase = 1'b0;
  assign inbuf_empty = empty_toggle ? empty_phase : empty_fixed;

  ec_stripe_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_en          (cfg_en),
    .start           (start),
    .abort           (abort),
    .cfg_k           (cfg_k),
    .cfg_m           (cfg_m),
    .cfg_num_stripes (cfg_num_stripes),
    .bm_rd_req       (bm_rd_req),
    .bm_rd_addr      (bm_rd_addr),
    .bm_rd_data_val  (bm_rd_data_val),
    .inbuf_empty     (inbuf_empty),
    .inbuf_rd_en     (inbuf_rd_en),
    .eng_clr         (eng_clr),
    .eng_calc_en     (eng_calc_en),
    .eng_empty       (eng_empty),
    .outbuf_full     (outbuf_full),
    .outbuf_wr_en    (outbuf_wr_en),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .stripe_idx      (stripe_idx),
    .parity_idx      (parity_idx)
  );

  always #5 clk = ~clk;

  // Bitmatrix memory answers every request two cycles later.
  logic val_d1 = 1'b0, val_d2 = 1'b0;
  always @(posedge clk) begin
    val_d1 <= bm_rd_req;
    val_d2 <= val_d1;
  end
  assign bm_rd_data_val = val_d2;

  // Engine reports busy for two cycles after each consumed word.
  logic calc_d1 = 1'b0, calc_d2 = 1'b0;
  always @(posedge clk) begin
    calc_d1 <= eng_calc_en;
    calc_d2 <= calc_d1;
  end
  assign eng_empty = !(calc_d1 || calc_d2);

  always @(negedge clk) empty_phase <= ~empty_phase;

  int n_req, n_rd, n_calc, n_wr, n_done, n_err, n_clr, n_skew, last_addr;
  logic clr_counts = 1'b0;
  logic prev_rd = 1'b0;

  always @(posedge clk) begin
    prev_rd <= inbuf_rd_en;
    if (clr_counts) begin
      n_req <= 0; n_rd <= 0; n_calc <= 0; n_wr <= 0; n_done <= 0;
      n_err <= 0; n_clr <= 0; n_skew <= 0; last_addr <= 0;
    end else if (!rst) begin
      if (bm_rd_req) begin
        n_req     <= n_req + 1;
        last_addr <= int'(bm_rd_addr);
      end
      if (inbuf_rd_en)  n_rd   <= n_rd + 1;
      if (eng_calc_en)  n_calc <= n_calc + 1;
      if (outbuf_wr_en) n_wr   <= n_wr + 1;
      if (done)         n_done <= n_done + 1;
      if (err)          n_err  <= n_err + 1;
      if (eng_clr)      n_clr  <= n_clr + 1;
      if (eng_calc_en !== prev_rd) n_skew <= n_skew + 1;
    end
  end

  int n_asserts = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int observed, input int expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk) clr_counts = 1'b1;
    @(negedge clk) clr_counts = 1'b0;
  endtask

  task automatic pulse_start(input int k, input int m, input int s);
    @(negedge clk);
    cfg_k = 4'(k);
    cfg_m = 3'(m);
    cfg_num_stripes = 16'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'({done, err}), 0);
    check("rst_req_rd_wr", int'({bm_rd_req, inbuf_rd_en, outbuf_wr_en}), 0);
    check("rst_idx", int'(stripe_idx) + int'(parity_idx), 0);
    rst = 1'b0;
    clear_counts();

    // K=4, M=2, one stripe, input always available.
    pulse_start(4, 2, 1);
    check("t1_busy", int'(busy), 1);
    check("t1_first_clr", int'(eng_clr), 1);
    wait_done("t1_done_seen", 500);
    check("t1_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("t1_req", n_req, 64);
    check("t1_last_addr", last_addr, 95);
    check("t1_rd", n_rd, 8);
    check("t1_calc", n_calc, 8);
    check("t1_wr", n_wr, 2);
    check("t1_done_cnt", n_done, 1);
    check("t1_clr_cnt", n_clr, 2);
    check("t1_skew", n_skew, 0);
    check("t1_idx", int'(parity_idx), 1);
    check("t1_busy_after", int'(busy), 0);

    // K=3, M=1, three stripes, input empty every other cycle.
    clear_counts();
    empty_toggle = 1'b1;
    pulse_start(3, 1, 3);
    wait_done("t2_done_seen", 800);
    @(negedge clk);
    empty_toggle = 1'b0;
    check("t2_rd", n_rd, 9);
    check("t2_calc", n_calc, 9);
    check("t2_wr", n_wr, 3);
    check("t2_req", n_req, 72);
    check("t2_skew", n_skew, 0);
    check("t2_done_cnt", n_done, 1);
    check("t2_stripe_idx", int'(stripe_idx), 2);

    // Output buffer full throughout WRITE.
    clear_counts();
    outbuf_full = 1'b1;
    pulse_start(1, 1, 1);
    repeat (40) @(negedge clk);
    check("t3_wr_held", n_wr, 0);
    check("t3_busy_held", int'(busy), 1);
    check("t3_wr_en_low", int'(outbuf_wr_en), 0);
    outbuf_full = 1'b0;
    #1;
    check("t3_wr_en_release", int'(outbuf_wr_en), 1);
    wait_done("t3_done_seen", 50);
    @(negedge clk);
    check("t3_wr", n_wr, 1);

    // Invalid configurations are rejected with a single err pulse.
    clear_counts();
    pulse_start(0, 1, 1);
    check("t4_err_k0", int'(err), 1);
    check("t4_busy_k0", int'(busy), 0);
    @(negedge clk);
    check("t4_err_pulse", int'(err), 0);
    pulse_start(2, 5, 1);
    check("t4_err_m5", int'(err), 1);
    pulse_start(9, 1, 1);
    check("t4_err_k9", int'(err), 1);
    pulse_start(2, 1, 0);
    check("t4_err_s0", int'(err), 1);
    repeat (3) @(negedge clk);
    check("t4_err_cnt", n_err, 4);
    check("t4_req", n_req, 0);
    check("t4_busy", int'(busy), 0);

    // Abort while stalled in RUN of the second stripe.
    clear_counts();
    begin
      bit reached = 1'b0;
      pulse_start(2, 1, 3);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (stripe_idx == 16'd1) begin
          reached = 1'b1;
          break;
        end
      end
      check("t5_reach_stripe1", int'(reached), 1);
    end
    empty_fixed = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_busy_stall", int'(busy), 1);
    check("t5_wr_stripe0", n_wr, 1);
    clear_counts();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("t5_busy_abort", int'(busy), 0);
    check("t5_clr_abort", int'(eng_clr), 1);
    check("t5_done_abort", int'(done), 0);
    repeat (10) @(negedge clk);
    check("t5_done_cnt", n_done, 0);
    check("t5_clr_cnt", n_clr, 1);
    check("t5_quiet", n_req + n_rd + n_wr, 0);
    empty_fixed = 1'b0;
    clear_counts();
    pulse_start(2, 1, 1);
    wait_done("t5_restart_done", 300);
    @(negedge clk);
    check("t5_restart_rd", n_rd, 2);
    check("t5_restart_wr", n_wr, 1);
    check("t5_restart_done_cnt", n_done, 1);

    // start while busy, then start with the accelerator disabled.
    clear_counts();
    pulse_start(2, 1, 1);
    repeat (3) @(negedge clk);
    pulse_start(8, 4, 5);
    wait_done("t6_done_seen", 300);
    @(negedge clk);
    check("t6_req", n_req, 16);
    check("t6_rd", n_rd, 2);
    check("t6_wr", n_wr, 1);
    check("t6_err", n_err, 0);
    repeat (5) @(negedge clk);
    check("t6_no_restart", int'(busy), 0);
    cfg_en = 1'b0;
    pulse_start(2, 1, 1);
    repeat (5) @(negedge clk);
    check("t6_dis_busy", int'(busy), 0);
    check("t6_dis_req", n_req, 16);
    check("t6_dis_err", n_err, 0);
    cfg_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
